// File: rtl/key_expand_serial.sv
// key_expand_serial
//   Byte-serial AES-128 key schedule feeding the encrypt block. The 16-byte
//   cipher key is loaded one byte per clock. Each round_req in READY then
//   streams the next round key one byte per clock. Round key bytes are
//   computed in place in a 16-byte register through a single shared S-box.
//
//   Optional feature macro: KEY_ECHO_EN
//     When defined, each accepted cipher key byte is echoed on key_out with
//     key_out_valid=1 one cycle after capture (round 0).
//
// Ports
//   clock          in   1  system clock, rising edge
//   reset          in   1  asynchronous active-high reset, returns to IDLE
//   key_in         in   8  cipher key byte, byte 0 (w0[31:24]) first
//   key_in_valid   in   1  key_in captured on this edge (IDLE/LOAD/DONE)
//   round_req      in   1  request next round key (sampled in READY only)
//   key_out        out  8  round key byte, registered
//   key_out_valid  out  1  key_out carries a valid byte
//   round_num      out  4  round key last produced (0 = cipher key)
//   busy           out  1  high in LOAD and GEN
//   done           out  1  high once NUM_ROUNDS round keys were streamed
module key_expand_serial #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] key_in,
  input  logic       key_in_valid,
  input  logic       round_req,
  output logic [7:0] key_out,
  output logic       key_out_valid,
  output logic [3:0] round_num,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_GEN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      else      p = p;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, 0 maps to 0)
  // followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] kreg_q [16];
  logic [7:0] rcon_q;
  logic [7:0] key_out_q;
  logic       key_out_valid_q;
  logic [3:0] round_num_q;
  logic       busy_q;
  logic       done_q;

  logic [7:0] sbox_in_d;
  logic [7:0] sbox_out_d;
  logic [7:0] new_byte_d;

  // The first word of a new round key uses RotWord: byte i reads the last
  // word's byte (i+1)%4. Later words chain on bytes already written back.
  always_comb begin
    sbox_in_d  = kreg_q[{2'b11, cnt_q[1:0] + 2'd1}];
    sbox_out_d = sbox(sbox_in_d);
    new_byte_d = 8'h00;
    if (cnt_q < 4'd4) begin
      new_byte_d = kreg_q[cnt_q] ^ sbox_out_d ^ ((cnt_q == 4'd0) ? rcon_q : 8'h00);
    end else begin
      new_byte_d = kreg_q[cnt_q] ^ kreg_q[cnt_q - 4'd4];
    end
  end

  // Control FSM, key register and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 4'd0;
      rcon_q          <= 8'h01;
      key_out_q       <= 8'h00;
      key_out_valid_q <= 1'b0;
      round_num_q     <= 4'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      for (int i = 0; i < 16; i++) kreg_q[i] <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (key_in_valid) begin
            kreg_q[0]   <= key_in;
            cnt_q       <= 4'd1;
            state_q     <= ST_LOAD;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            round_num_q <= 4'd0;
            rcon_q      <= 8'h01;
`ifdef KEY_ECHO_EN
            key_out_q       <= key_in;
            key_out_valid_q <= 1'b1;
`else
            key_out_valid_q <= 1'b0;
`endif
          end else begin
            key_out_valid_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (key_in_valid) begin
            kreg_q[cnt_q] <= key_in;
`ifdef KEY_ECHO_EN
            key_out_q       <= key_in;
            key_out_valid_q <= 1'b1;
`else
            key_out_valid_q <= 1'b0;
`endif
            if (cnt_q == 4'd15) begin
              cnt_q       <= 4'd0;
              state_q     <= ST_READY;
              busy_q      <= 1'b0;
              round_num_q <= 4'd0;
              rcon_q      <= 8'h01;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            key_out_valid_q <= 1'b0;
          end
        end
        ST_READY: begin
          key_out_valid_q <= 1'b0;
          if (round_req) begin
            state_q <= ST_GEN;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_READY;
          end
        end
        ST_GEN: begin
          kreg_q[cnt_q]   <= new_byte_d;
          key_out_q       <= new_byte_d;
          key_out_valid_q <= 1'b1;
          if (cnt_q == 4'd15) begin
            cnt_q       <= 4'd0;
            round_num_q <= round_num_q + 4'd1;
            rcon_q      <= xtime(rcon_q);
            busy_q      <= 1'b0;
            if (round_num_q + 4'd1 == LAST_ROUND) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_READY;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q         <= ST_IDLE;
          key_out_valid_q <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  assign key_out       = key_out_q;
  assign key_out_valid = key_out_valid_q;
  assign round_num     = round_num_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_key_expand_serial.sv
// Testbench for key_expand_serial: a word-level AES-128 key expansion model
// (S-box found by brute-force inverse search) plus fixed known-answer values.
module tb_key_expand_serial;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       key_in_valid = 1'b0;
  logic       round_req = 1'b0;
  logic [7:0] key_out;
  logic       key_out_valid;
  logic [3:0] round_num;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  exp_w [44];
  logic [127:0] cap_key;
  int           cap_wait;
  int           cap_vcnt;
  bit           cap_timeout;
  logic         cap_tail;

  key_expand_serial #(.NUM_ROUNDS(NR)) dut (
    .clock(clock), .reset(reset), .key_in(key_in), .key_in_valid(key_in_valid),
    .round_req(round_req), .key_out(key_out), .key_out_valid(key_out_valid),
    .round_num(round_num), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s   = 8'h63;
    for (int y = 1; y < 256; y++)
      if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = s[i] ^ inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                  ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    return s;
  endfunction

  task automatic build_model(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) exp_w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = exp_w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        t = t ^ {rc, 24'h000000};
        rc = m_mul(rc, 8'h02);
      end
      exp_w[i] = exp_w[i - 4] ^ t;
    end
  endtask

  function automatic logic [127:0] m_round(input int r);
    return {exp_w[4 * r], exp_w[4 * r + 1], exp_w[4 * r + 2], exp_w[4 * r + 3]};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; key_in_valid = 1'b0; round_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic load_key(input logic [127:0] k, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      key_in = k[127 - 8 * i -: 8]; key_in_valid = 1'b1;
      tick();
      if (gaps) begin
        key_in_valid = 1'b0; key_in = 8'($urandom);
        tick();
      end
    end
    key_in_valid = 1'b0;
  endtask

  // Caller sets round_req before calling; the first tick is the request edge.
  task automatic capture_stream(input bit pulse);
    cap_timeout = 1'b0; cap_wait = 0; cap_vcnt = 0; cap_key = '0;
    tick();
    if (pulse) round_req = 1'b0;
    while (!key_out_valid) begin
      if (cap_wait == 6) begin cap_timeout = 1'b1; return; end
      tick(); cap_wait++;
    end
    for (int i = 0; i < 16; i++) begin
      cap_key = {cap_key[119:0], key_out};
      if (key_out_valid) cap_vcnt++;
      tick();
    end
    cap_tail = key_out_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; tick(); #2;
    n_checks++; if (key_out !== 8'h00) begin n_fail++; $display("FAIL reset_key_out: got %h want 00", key_out); end
    n_checks++; if (key_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_out_valid); end
    n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL reset_round_num: got %0d want 0", round_num); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0; tick();
  endtask

  task automatic test_fips_vector();
    logic [7:0] b;
    build_model(FIPS_KEY);
    for (int i = 0; i < 16; i++) begin
      b = FIPS_KEY[127 - 8 * i -: 8];
      key_in = b; key_in_valid = 1'b1;
      tick();
`ifdef KEY_ECHO_EN
      n_checks++; if (key_out_valid !== 1'b1) begin n_fail++; $display("FAIL echo_valid byte %0d: got %b want 1", i, key_out_valid); end
      n_checks++; if (key_out !== b) begin n_fail++; $display("FAIL echo_byte %0d: got %h want %h", i, key_out, b); end
      n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL echo_round %0d: got %0d want 0", i, round_num); end
`else
      n_checks++; if (key_out_valid !== 1'b0) begin n_fail++; $display("FAIL load_quiet byte %0d: got %b want 0", i, key_out_valid); end
`endif
      if (i == 0) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", busy); end
      end
    end
    key_in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ready_busy: got %b want 0", busy); end
    n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL ready_round: got %0d want 0", round_num); end
    round_req = 1'b1;
    capture_stream(1'b1);
    n_checks++; if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL r1_timeout: got %b want 0", cap_timeout); end
    n_checks++; if (cap_wait !== 1) begin n_fail++; $display("FAIL r1_latency: got %0d want 1", cap_wait); end
    n_checks++; if (cap_vcnt !== 16) begin n_fail++; $display("FAIL r1_len: got %0d want 16", cap_vcnt); end
    n_checks++; if (cap_key !== FIPS_R1) begin n_fail++; $display("FAIL r1_known: got %h want %h", cap_key, FIPS_R1); end
    n_checks++; if (cap_tail !== 1'b0) begin n_fail++; $display("FAIL r1_tail: got %b want 0", cap_tail); end
    n_checks++; if (round_num !== 4'd1) begin n_fail++; $display("FAIL r1_round: got %0d want 1", round_num); end
  endtask

  task automatic test_back_to_back();
    int vc = 0;
    round_req = 1'b1;
    for (int r = 2; r <= NR; r++) begin
      capture_stream(1'b0);
      n_checks++; if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout r%0d: got %b want 0", r, cap_timeout); end
      n_checks++; if (cap_wait !== ((r == 2) ? 1 : 0)) begin n_fail++; $display("FAIL b2b_gap r%0d: got %0d want %0d", r, cap_wait, (r == 2) ? 1 : 0); end
      n_checks++; if (cap_key !== m_round(r)) begin n_fail++; $display("FAIL b2b_key r%0d: got %h want %h", r, cap_key, m_round(r)); end
      n_checks++; if (round_num !== 4'(r)) begin n_fail++; $display("FAIL b2b_round r%0d: got %0d want %0d", r, round_num, r); end
      if (r == 2) begin
        n_checks++; if (cap_key !== FIPS_R2) begin n_fail++; $display("FAIL r2_known: got %h want %h", cap_key, FIPS_R2); end
      end
      if (r == 10) begin
        n_checks++; if (cap_key !== FIPS_R10) begin n_fail++; $display("FAIL r10_known: got %h want %h", cap_key, FIPS_R10); end
      end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_set: got %b want 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy: got %b want 0", busy); end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (key_out_valid) vc++;
    end
    round_req = 1'b0;
    n_checks++; if (vc !== 0) begin n_fail++; $display("FAIL done_no_output: got %0d valid cycles want 0", vc); end
    n_checks++; if (round_num !== 4'(NR)) begin n_fail++; $display("FAIL done_round_hold: got %0d want %0d", round_num, NR); end
  endtask

  task automatic test_gap_load();
    load_key(FIPS_KEY, 1'b1);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL gap_done_clear: got %b want 0", done); end
    n_checks++; if (round_num !== 4'd0) begin n_fail++; $display("FAIL gap_round: got %0d want 0", round_num); end
    round_req = 1'b1;
    capture_stream(1'b1);
    n_checks++; if (cap_key !== FIPS_R1) begin n_fail++; $display("FAIL gap_r1: got %h want %h", cap_key, FIPS_R1); end
  endtask

  task automatic test_reset_mid_stream();
    logic [127:0] r3;
    int vc = 0;
    apply_reset();
    build_model(FIPS_KEY);
    r3 = m_round(3);
    load_key(FIPS_KEY, 1'b0);
    round_req = 1'b1; capture_stream(1'b1);
    round_req = 1'b1; capture_stream(1'b1);
    round_req = 1'b1; tick(); round_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_checks++; if (key_out !== r3[71:64]) begin n_fail++; $display("FAIL r3_byte7: got %h want %h", key_out, r3[71:64]); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({key_out, key_out_valid, round_num, busy, done} !== 15'h0) begin
      n_fail++; $display("FAIL async_reset_outputs: got %h/%b/%0d/%b/%b want all 0", key_out, key_out_valid, round_num, busy, done);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (key_out_valid) vc++;
    end
    n_checks++; if (vc !== 0) begin n_fail++; $display("FAIL post_reset_quiet: got %0d valid cycles want 0", vc); end
    load_key(FIPS_KEY, 1'b0);
    round_req = 1'b1; capture_stream(1'b1);
    n_checks++; if (cap_key !== FIPS_R1) begin n_fail++; $display("FAIL reload_r1: got %h want %h", cap_key, FIPS_R1); end
  endtask

  task automatic test_req_during_gen();
    logic [127:0] got = '0;
    int vc = 0;
    round_req = 1'b1; tick(); round_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (key_out_valid) begin got = {got[119:0], key_out}; vc++; end
      round_req = (c == 5);
    end
    round_req = 1'b0;
    n_checks++; if (vc !== 16) begin n_fail++; $display("FAIL gen_req_len: got %0d want 16", vc); end
    n_checks++; if (round_num !== 4'd2) begin n_fail++; $display("FAIL gen_req_round: got %0d want 2", round_num); end
    n_checks++; if (got !== m_round(2)) begin n_fail++; $display("FAIL gen_req_key: got %h want %h", got, m_round(2)); end
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      build_model(k);
      load_key(k, t == 1);
      round_req = 1'b1;
      for (int r = 1; r <= NR; r++) begin
        capture_stream(1'b0);
        n_checks++; if (cap_timeout !== 1'b0 || cap_key !== m_round(r)) begin
          n_fail++; $display("FAIL rand_key%0d r%0d: got %h want %h (timeout %b)", t, r, cap_key, m_round(r), cap_timeout);
        end
      end
      round_req = 1'b0;
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rand_done key%0d: got %b want 1", t, done); end
    end
  endtask

  initial begin
    test_reset();
    test_fips_vector();
    test_back_to_back();
    test_gap_load();
    test_reset_mid_stream();
    test_req_during_gen();
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
